// File: rtl/multiplier_n_bits_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

    // Default operand width in bits; the product is twice this width.
    localparam int MULT_W_DEFAULT = 8;

    // Control states of the iterative multiplier.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/multiplier_n_bits_seq_operand_buffer_reg.sv
// Operand buffer: W-bit register with load enable and async active-low reset.
module operand_buffer_reg
    import mult_pkg::*;
#(
    parameter int W = MULT_W_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Capture the data bus whenever load is asserted, independent of any operation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : operand_buffer_reg

// File: rtl/multiplier_n_bits_seq.sv
// Sequential radix-2 shift-add multiplier with double-buffered operands.
// A start pulse in IDLE copies the buffers into working registers, RUN
// iterates N times, FINISH publishes the product and pulses done.
// Optional build macro MULT_SIGNED_EN adds i_signed_mode for two's-complement
// operands (magnitudes multiplied, sign applied when the result is written).
module multiplier_n_bits_seq
    import mult_pkg::*;
#(
    parameter int N = MULT_W_DEFAULT
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_data_in,
    input  logic           i_load_a,
    input  logic           i_load_b,
    input  logic           i_start,
`ifdef MULT_SIGNED_EN
    input  logic           i_signed_mode,
`endif
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_result,
    output logic [N-1:0]   o_op_a,
    output logic [N-1:0]   o_op_b
);

    localparam int CNT_W = $clog2(N);

    // Operand buffers; loads only ever touch these, never the working registers.
    logic [N-1:0] w_op_a;
    logic [N-1:0] w_op_b;

    operand_buffer_reg #(.W(N)) u_buf_a (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (i_load_a),
        .i_d     (i_data_in),
        .o_q     (w_op_a)
    );

    operand_buffer_reg #(.W(N)) u_buf_b (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (i_load_b),
        .i_d     (i_data_in),
        .o_q     (w_op_b)
    );

    // Magnitudes fed to the iterative datapath and the sign of the product.
    // The magnitude of the most negative value still fits as unsigned N bits.
    logic [N-1:0] w_abs_a;
    logic [N-1:0] w_abs_b;
    logic         w_sign;

`ifdef MULT_SIGNED_EN
    assign w_abs_a = (i_signed_mode && w_op_a[N-1]) ? (-w_op_a) : w_op_a;
    assign w_abs_b = (i_signed_mode && w_op_b[N-1]) ? (-w_op_b) : w_op_b;
    assign w_sign  = i_signed_mode && (w_op_a[N-1] ^ w_op_b[N-1]);
`else
    assign w_abs_a = w_op_a;
    assign w_abs_b = w_op_b;
    assign w_sign  = 1'b0;
`endif

    mult_state_t      r_state;
    logic [2*N-1:0]   r_mcand;
    logic [N-1:0]     r_mplier;
    logic [2*N-1:0]   r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign;
    logic             r_busy;
    logic             r_done;
    logic [2*N-1:0]   r_result;

    // Control FSM and datapath; busy/done/result are registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_mcand  <= {{N{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_sign   <= w_sign;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // The iteration that sees cnt == N-1 is the N-th and last one.
                    if (r_cnt == CNT_W'(N - 1)) begin
                        r_state <= FINISH;
                    end
                end
                FINISH: begin
                    r_result <= r_sign ? (-r_acc) : r_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_op_a   = w_op_a;
    assign o_op_b   = w_op_b;

endmodule : multiplier_n_bits_seq

// File: tb/tb_multiplier_n_bits_seq.sv
// Directed self-checking bench for multiplier_n_bits_seq (N=8).
module tb_multiplier_n_bits_seq;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   i_data_in;
    logic           i_load_a;
    logic           i_load_b;
    logic           i_start;
`ifdef MULT_SIGNED_EN
    logic           i_signed_mode;
`endif
    logic           o_busy;
    logic           o_done;
    logic [2*N-1:0] o_result;
    logic [N-1:0]   o_op_a;
    logic [N-1:0]   o_op_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    multiplier_n_bits_seq #(.N(N)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data_in     (i_data_in),
        .i_load_a      (i_load_a),
        .i_load_b      (i_load_b),
        .i_start       (i_start),
`ifdef MULT_SIGNED_EN
        .i_signed_mode (i_signed_mode),
`endif
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_result      (o_result),
        .o_op_a        (o_op_a),
        .o_op_b        (o_op_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: load A then B on consecutive edges.
    task automatic load_ops(input logic [N-1:0] a, input logic [N-1:0] b);
        i_data_in = a; i_load_a = 1'b1; tick(); i_load_a = 1'b0;
        i_data_in = b; i_load_b = 1'b1; tick(); i_load_b = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; i_data_in = '0; i_load_a = 0; i_load_b = 0; i_start = 0;
`ifdef MULT_SIGNED_EN
        i_signed_mode = 1'b0;
`endif
        #3;
        vec_cnt++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 16'h0000 ||
            o_op_a !== 8'h00 || o_op_b !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_state busy=%b done=%b result=%h op_a=%h op_b=%h required all 0",
                     o_busy, o_done, o_result, o_op_a, o_op_b);
        end
        tick();
        rst_n = 1'b1;
        $display("reset: outputs checked");
    endtask

    task automatic test_basic;
        load_ops(8'd13, 8'd11);
        vec_cnt++;
        if (o_op_a !== 8'h0D || o_op_b !== 8'h0B) begin
            err_cnt++;
            $display("FAIL basic_ops op_a=%h op_b=%h required 0d 0b", o_op_a, o_op_b);
        end
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int c = 0; c <= N; c++) begin
            vec_cnt++;
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_result !== 16'h0000) begin
                err_cnt++;
                $display("FAIL basic_busy cycle %0d busy=%b done=%b result=%h required 1 0 0000",
                         c, o_busy, o_done, o_result);
            end
            tick();
        end
        vec_cnt++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_result !== 16'h008F) begin
            err_cnt++;
            $display("FAIL basic_done done=%b busy=%b result=%h required 1 0 008f",
                     o_done, o_busy, o_result);
        end
        tick();
        vec_cnt++;
        if (o_done !== 1'b0 || o_result !== 16'h008F) begin
            err_cnt++;
            $display("FAIL basic_pulse done=%b result=%h required 0 008f", o_done, o_result);
        end
        $display("basic: 13 x 11 result=%h", o_result);
    endtask

    task automatic test_extremes;
        int n_done;
        logic [N-1:0]   a_tab [2] = '{8'd255, 8'd0};
        logic [N-1:0]   b_tab [2] = '{8'd255, 8'd200};
        logic [2*N-1:0] p_tab [2] = '{16'hFE01, 16'h0000};
        for (int t = 0; t < 2; t++) begin
            load_ops(a_tab[t], b_tab[t]);
            i_start = 1'b1; tick(); i_start = 1'b0;
            n_done = 0;
            for (int c = 0; c < N + 4; c++) begin
                tick();
                if (o_done === 1'b1) n_done++;
            end
            vec_cnt++;
            if (n_done != 1 || o_result !== p_tab[t]) begin
                err_cnt++;
                $display("FAIL extreme_%0d dones=%0d result=%h required 1 %h",
                         t, n_done, o_result, p_tab[t]);
            end
            $display("extreme: %0d x %0d result=%h dones=%0d", a_tab[t], b_tab[t], o_result, n_done);
        end
    endtask

    task automatic test_load_during_busy;
        load_ops(8'd6, 8'd7);
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick(); tick();
        i_data_in = 8'd9; i_load_a = 1'b1; tick(); i_load_a = 1'b0;
        vec_cnt++;
        if (o_op_a !== 8'd9 || o_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL busy_load op_a=%0d busy=%b required 9 1", o_op_a, o_busy);
        end
        for (int c = 0; c < 40; c++) begin
            if (o_done === 1'b1) break;
            tick();
        end
        vec_cnt++;
        if (o_done !== 1'b1 || o_result !== 16'd42) begin
            err_cnt++;
            $display("FAIL busy_load_result done=%b result=%0d required 1 42", o_done, o_result);
        end
        tick();
        // Start and a load on the same edge: the product uses the old buffer.
        i_start = 1'b1; i_load_a = 1'b1; i_data_in = 8'd1; tick();
        i_start = 1'b0; i_load_a = 1'b0;
        vec_cnt++;
        if (o_op_a !== 8'd1 || o_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL start_load op_a=%0d busy=%b required 1 1", o_op_a, o_busy);
        end
        for (int c = 0; c < 40; c++) begin
            if (o_done === 1'b1) break;
            tick();
        end
        vec_cnt++;
        if (o_done !== 1'b1 || o_result !== 16'd63) begin
            err_cnt++;
            $display("FAIL start_load_result done=%b result=%0d required 1 63", o_done, o_result);
        end
        tick();
        $display("load_during_busy: result=%0d", o_result);
    endtask

    task automatic test_back_to_back;
        int n_done;
        logic [2*N-1:0] res1;
        res1 = '0;
        load_ops(8'd2, 8'd3);
        i_start = 1'b1; tick();
        i_data_in = 8'd4; i_load_a = 1'b1; tick(); i_load_a = 1'b0;
        n_done = 0;
        for (int c = 0; c < N + 1; c++) begin
            tick();
            if (o_done === 1'b1) begin n_done++; res1 = o_result; end
        end
        vec_cnt++;
        if (n_done != 1 || res1 !== 16'd6 || o_busy !== 1'b1 || o_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_first dones=%0d result=%0d busy=%b done=%b required 1 6 1 0",
                     n_done, res1, o_busy, o_done);
        end
        i_start = 1'b0;
        n_done = 0;
        for (int c = 0; c < N + 3; c++) begin
            tick();
            if (o_done === 1'b1) n_done++;
        end
        vec_cnt++;
        if (n_done != 1 || o_result !== 16'd12 || o_busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL b2b_second dones=%0d result=%0d busy=%b required 1 12 0",
                     n_done, o_result, o_busy);
        end
        $display("back_to_back: first=%0d second=%0d", res1, o_result);
    endtask

    task automatic test_reset_mid_run;
        load_ops(8'd13, 8'd11);
        i_start = 1'b1; tick(); i_start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_result !== 16'h0000 ||
            o_op_a !== 8'h00 || o_op_b !== 8'h00) begin
            err_cnt++;
            $display("FAIL mid_reset busy=%b done=%b result=%h op_a=%h op_b=%h required all 0",
                     o_busy, o_done, o_result, o_op_a, o_op_b);
        end
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < N + 2; c++) begin
            tick();
            vec_cnt++;
            if (o_done !== 1'b0 || o_busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL mid_reset_quiet cycle %0d done=%b busy=%b required 0 0",
                         c, o_done, o_busy);
            end
        end
        load_ops(8'd3, 8'd5);
        i_start = 1'b1; tick(); i_start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (o_done === 1'b1) break;
            tick();
        end
        vec_cnt++;
        if (o_done !== 1'b1 || o_result !== 16'd15) begin
            err_cnt++;
            $display("FAIL after_reset done=%b result=%0d required 1 15", o_done, o_result);
        end
        tick();
        $display("reset_mid_run: fresh 3 x 5 result=%0d", o_result);
    endtask

    task automatic test_signed;
        logic [N-1:0]   a_tab [4] = '{8'hFD, 8'h80, 8'h80, 8'hFD};
        logic [N-1:0]   b_tab [4] = '{8'h05, 8'h80, 8'h01, 8'h05};
        logic           m_tab [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [2*N-1:0] p_tab [4] = '{16'hFFF1, 16'h4000, 16'hFF80, 16'h04F1};
`ifndef MULT_SIGNED_EN
        // Without signed support only the unsigned vector applies.
        for (int t = 3; t < 4; t++) begin
`else
        for (int t = 0; t < 4; t++) begin
            i_signed_mode = m_tab[t];
`endif
            load_ops(a_tab[t], b_tab[t]);
            i_start = 1'b1; tick(); i_start = 1'b0;
`ifdef MULT_SIGNED_EN
            i_signed_mode = 1'b0;
`endif
            for (int c = 0; c < 40; c++) begin
                if (o_done === 1'b1) break;
                tick();
            end
            vec_cnt++;
            if (o_done !== 1'b1 || o_result !== p_tab[t]) begin
                err_cnt++;
                $display("FAIL signed_%0d mode=%b done=%b result=%h required 1 %h",
                         t, m_tab[t], o_done, o_result, p_tab[t]);
            end
            $display("signed: a=%h b=%h mode=%b result=%h", a_tab[t], b_tab[t], m_tab[t], o_result);
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_load_during_busy();
        test_back_to_back();
        test_reset_mid_run();
        test_signed();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule : tb_multiplier_n_bits_seq

// File: doc/multiplier_n_bits_seq.md
Name: multiplier_n_bits_seq

Overview:
- Parametrised sequential shift-add multiplier with double-buffered operand registers and a start/busy/done handshake.
- Operands A and B are loaded one at a time from a single N-bit data bus.
- A start pulse launches an N-cycle radix-2 multiply; the 2N-bit product is held in a result register until the next completion.
- Next-generation replacement for the 8-bit buffered multiplier behind the board wrappers: any width, iterative datapath, optional signed mode.

Parameters:
- N, 8, operand width in bits; must be ≥ 2; product width is 2N.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  N  operand data bus.
- load_a  input  1  capture data_in into operand buffer A.
- load_b  input  1  capture data_in into operand buffer B.
- start  input  1  launch a multiply of the current A and B buffer contents.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  2N  last completed product.
- op_a  output  N  operand buffer A contents, for display.
- op_b  output  N  operand buffer B contents, for display.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; op_a, op_b, result, internal accumulator and counter all 0; busy=0, done=0.
- Operand buffers:
  - load_a/load_b are sampled every edge, in any state.
  - Both high in the same cycle: both buffers take data_in.
  - A load changes only the buffer, never an operation already in flight.
- States IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge k: copy op_a into the multiplicand working register (zero-extended to 2N), copy op_b into the multiplier shift register, clear acc and cnt, go to RUN.
  - The copy uses buffer values from before edge k; a load in the same cycle affects only the next operation.
- RUN, each edge:
  - If multiplier LSB=1, acc += multiplicand.
  - Multiplicand shifts left 1; multiplier shifts right 1; cnt++.
  - When cnt reaches N-1 on this edge (N-th iteration), go to FINISH.
- FINISH, one edge: result <= acc, done=1 for exactly that following cycle, return to IDLE.
- Timing:
  - busy=1 exactly in RUN and FINISH, i.e. the N+1 cycles after edge k.
  - done is high during the cycle after edge k+N+1.
  - Total latency from start to result valid: N+2 edges.
- start while busy=1 is ignored (not queued).
- result is stable between done pulses; it is never partially updated.
- Arithmetic: unsigned; acc is 2N bits; overflow is impossible ((2^N−1)^2 < 2^2N).
- cnt width is $clog2(N).
- Reset mid-operation aborts immediately; result returns to 0 and no done pulse is issued.
- start and done in the same cycle: done completes, and start is accepted from IDLE on the next edge only if still asserted.

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled with start.
  - When signed_mode=1, operands are two's complement: at start, working registers take the absolute values and the sign XOR is latched.
  - In FINISH, result <= sign ? −acc : acc (2N-bit two's complement).
  - Most-negative operand (−2^(N−1)) is handled correctly, because the absolute value fits as unsigned N bits.
  - Latency is unchanged.
- Not defined: no signed_mode port; behaviour is purely unsigned as above.

Decomposition:
- Package mult_pkg: state enum (IDLE, RUN, FINISH) and the default width constant MULT_W_DEFAULT=8.
- One natural sub-module: operand_buffer_reg. It is an N-bit register with asynchronous active-low reset and load enable, and is instantiated twice for A and B.
- The board wrapper continues to drive hex decoders from result.

Test Plan:
1. N=8: load_a with 13, load_b with 11, start → busy for 9 cycles, done pulse at edge 10, result=0x008F, op_a=0x0D, op_b=0x0B.
2. N=8: A=255, B=255 → result=0xFE01; then A=0, B=200 → result=0x0000, done pulses once per operation.
3. Loads during busy: start 6×7, then load_a with 9 on cycle 3 → result=42, op_a=9; a second start gives 63.
4. start re-asserted during busy and start held high across FINISH → only one done per accepted start; the held start launches the next operation right after IDLE is re-entered.
5. rst_n low on cycle 4 of a run → all outputs 0 immediately, no done; a fresh 3×5 afterwards gives 15.
6. MULT_SIGNED_EN, N=8, signed_mode=1:
   - −3×5 → 0xFFF1
   - −128×−128 → 0x4000
   - −128×1 → 0xFF80
   - Same operands with signed_mode=0: 253×5 → 0x04F1.
